// File: rtl/ps2_mouse_pkt_ctrl.sv
// PS/2 mouse packet framer: turns the received byte stream into 3-byte
// packets and decodes them into buttons, signed motion and overflow.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   in_valid        in_byte carries a newly received byte this cycle
//   in_byte         received byte
//   out_valid       a packet is held in the output register
//   out_ready       consumer takes the held packet this cycle
//   out_bytes       {byte1, byte2, byte3} of the held packet
//   btn             {middle, right, left} buttons
//   dx, dy          signed 9-bit motion
//   ovf             either axis overflowed
//   sync_err        one-cycle pulse per framing discard or timeout
//   drop_count      saturating count of packets lost to backpressure
module ps2_mouse_pkt_ctrl #(
  parameter int TIMEOUT = 1000,
  parameter int DROP_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [23:0]       out_bytes,
  output logic [2:0]        btn,
  output logic signed [8:0] dx,
  output logic signed [8:0] dy,
  output logic              ovf,
  output logic              sync_err,
  output logic [DROP_W-1:0] drop_count
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B2   = 2'd1,
    B3   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] idle_cnt;
  logic [7:0]       byte1;
  logic [7:0]       byte2;

  logic mid_pkt;
  logic timeout_hit;
  logic take_b1;
  logic take_b2;
  logic pkt_done;
  logic frame_err;
  logic load;
  logic drop;
  logic xfer;

  assign mid_pkt = (state != IDLE);

  // The idle cycle that would carry the count to TIMEOUT fires the
  // timeout directly; a byte on that cycle is simply accepted instead.
  assign timeout_hit = mid_pkt && !in_valid
                    && (idle_cnt == CNT_LAST);

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid && in_byte[3]) begin
          state_nxt = B2;
        end
      end
      B2: begin
        if (in_valid) begin
          state_nxt = B3;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      B3: begin
        if (in_valid || timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- output (control) logic ----
  always_comb begin
    take_b1   = 1'b0;
    take_b2   = 1'b0;
    pkt_done  = 1'b0;
    frame_err = 1'b0;
    unique case (state)
      IDLE: begin
        take_b1   = in_valid && in_byte[3];
        frame_err = in_valid && !in_byte[3];
      end
      B2: begin
        take_b2 = in_valid;
      end
      B3: begin
        pkt_done = in_valid;
      end
      default: begin
        take_b1 = 1'b0;
      end
    endcase
  end

  // ---- idle counter: runs only mid-packet while no byte arrives ----
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (!mid_pkt || in_valid || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // ---- partial packet bytes ----
  always_ff @(posedge clk) begin
    if (reset) begin
      byte1 <= '0;
      byte2 <= '0;
    end else begin
      if (take_b1) begin
        byte1 <= in_byte;
      end
      if (take_b2) begin
        byte2 <= in_byte;
      end
    end
  end

  // ---- one-entry output register ----
  assign xfer = out_valid && out_ready;
  assign load = pkt_done && (!out_valid || out_ready);
  assign drop = pkt_done && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_bytes <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_bytes <= {byte1, byte2, in_byte};
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= frame_err || timeout_hit;
    end
  end

  // ---- decode from the held packet ----
  assign btn = out_bytes[18:16];
  assign dx  = {out_bytes[20], out_bytes[15:8]};
  assign dy  = {out_bytes[21], out_bytes[7:0]};
  assign ovf = out_bytes[23] | out_bytes[22];

endmodule

// File: tb/tb_ps2_mouse_pkt_ctrl.sv
// Directed bench for ps2_mouse_pkt_ctrl: framing, resync, timeout,
// backpressure drops, mid-packet reset and counter saturation.
module tb_ps2_mouse_pkt_ctrl;

  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_byte = 8'h00;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [23:0]       out_bytes;
  logic [2:0]        btn;
  logic signed [8:0] dx;
  logic signed [8:0] dy;
  logic              ovf;
  logic              sync_err;
  logic [7:0]        drop_count;

  logic              in_valid2 = 1'b0;
  logic [7:0]        in_byte2 = 8'h00;
  logic              out_valid2;
  logic              out_ready2 = 1'b0;
  logic [23:0]       out_bytes2;
  logic [2:0]        btn2;
  logic signed [8:0] dx2;
  logic signed [8:0] dy2;
  logic              ovf2;
  logic              sync_err2;
  logic [1:0]        drop_count2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ps2_mouse_pkt_ctrl #(.TIMEOUT(TMO), .DROP_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_byte(in_byte),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bytes(out_bytes), .btn(btn), .dx(dx), .dy(dy),
    .ovf(ovf), .sync_err(sync_err), .drop_count(drop_count)
  );

  ps2_mouse_pkt_ctrl #(.TIMEOUT(TMO), .DROP_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_byte(in_byte2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_bytes(out_bytes2), .btn(btn2), .dx(dx2), .dy(dy2),
    .ovf(ovf2), .sync_err(sync_err2), .drop_count(drop_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_byte2(input logic [7:0] b);
    in_valid2 = 1'b1;
    in_byte2  = b;
    tick();
    in_valid2 = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_valid got %0b want 0", out_valid);
    end
    vectors++;
    if (out_bytes !== 24'h0 || dx !== 9'h0 || dy !== 9'h0
        || btn !== 3'h0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_data got %h want 000000", out_bytes);
    end
    vectors++;
    if (sync_err !== 1'b0 || drop_count !== 8'h0) begin
      miscompares++;
      $display("FAIL rst_flags got %0b/%0d want 0/0",
               sync_err, drop_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    send_byte(8'h08);
    send_byte(8'h05);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early got %0b want 0", out_valid);
    end
    send_byte(8'hFB);
    vectors++;
    if (out_valid !== 1'b1 || out_bytes !== 24'h0805FB) begin
      miscompares++;
      $display("FAIL basic_pkt got %0b/%h want 1/0805fb",
               out_valid, out_bytes);
    end
    vectors++;
    if (btn !== 3'd0 || dx !== 9'h005 || dy !== 9'h0FB
        || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_dec got %0d/%h/%h/%0b want 0/005/0fb/0",
               btn, dx, dy, ovf);
    end
    consume();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_xfer got %0b want 0", out_valid);
    end
  endtask

  task automatic test_resync();
    send_byte(8'h00);
    vectors++;
    if (sync_err !== 1'b1) begin
      miscompares++;
      $display("FAIL resync_err1 got %0b want 1", sync_err);
    end
    send_byte(8'h12);
    vectors++;
    if (sync_err !== 1'b1) begin
      miscompares++;
      $display("FAIL resync_err2 got %0b want 1", sync_err);
    end
    send_byte(8'h39);
    vectors++;
    if (sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL resync_clr got %0b want 0", sync_err);
    end
    send_byte(8'h80);
    send_byte(8'h01);
    vectors++;
    if (out_valid !== 1'b1 || out_bytes !== 24'h398001) begin
      miscompares++;
      $display("FAIL resync_pkt got %0b/%h want 1/398001",
               out_valid, out_bytes);
    end
    vectors++;
    if (btn !== 3'd1 || dx !== 9'h180 || dy !== 9'h101
        || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL resync_dec got %0d/%h/%h/%0b want 1/180/101/0",
               btn, dx, dy, ovf);
    end
    consume();
  endtask

  task automatic test_timeout();
    send_byte(8'h08);
    send_byte(8'h01);
    repeat (TMO - 1) tick();
    vectors++;
    if (sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_early got %0b want 0", sync_err);
    end
    tick();
    vectors++;
    if (sync_err !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_pulse got %0b want 1", sync_err);
    end
    tick();
    vectors++;
    if (sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_once got %0b want 0", sync_err);
    end
    send_byte(8'h08);
    send_byte(8'h02);
    send_byte(8'h03);
    vectors++;
    if (out_valid !== 1'b1 || out_bytes !== 24'h080203) begin
      miscompares++;
      $display("FAIL tmo_pkt got %0b/%h want 1/080203",
               out_valid, out_bytes);
    end
    consume();
  endtask

  task automatic test_timeout_edge();
    send_byte(8'h08);
    repeat (TMO - 1) tick();
    send_byte(8'h04);
    vectors++;
    if (sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL tmoedge_err got %0b want 0", sync_err);
    end
    send_byte(8'h06);
    vectors++;
    if (out_valid !== 1'b1 || out_bytes !== 24'h080406) begin
      miscompares++;
      $display("FAIL tmoedge_pkt got %0b/%h want 1/080406",
               out_valid, out_bytes);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send_byte(8'h09); send_byte(8'h10); send_byte(8'h20);
    send_byte(8'h0A); send_byte(8'h11); send_byte(8'h21);
    send_byte(8'h0B); send_byte(8'h12); send_byte(8'h22);
    vectors++;
    if (out_valid !== 1'b1 || out_bytes !== 24'h091020) begin
      miscompares++;
      $display("FAIL bp_hold got %0b/%h want 1/091020",
               out_valid, out_bytes);
    end
    vectors++;
    if (drop_count !== 8'd2) begin
      miscompares++;
      $display("FAIL bp_drops got %0d want 2", drop_count);
    end
    send_byte(8'h0C);
    send_byte(8'h13);
    in_valid  = 1'b1;
    in_byte   = 8'h23;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_bytes !== 24'h0C1323) begin
      miscompares++;
      $display("FAIL bp_swap got %0b/%h want 1/0c1323",
               out_valid, out_bytes);
    end
    vectors++;
    if (drop_count !== 8'd2 || btn !== 3'd4) begin
      miscompares++;
      $display("FAIL bp_after got %0d/%0d want 2/4", drop_count, btn);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h08);
    send_byte(8'h07);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL rstmid_state got %0b/%0d want 0/0",
               out_valid, drop_count);
    end
    send_byte(8'h28);
    send_byte(8'h03);
    send_byte(8'h04);
    vectors++;
    if (out_valid !== 1'b1 || out_bytes !== 24'h280304) begin
      miscompares++;
      $display("FAIL rstmid_pkt got %0b/%h want 1/280304",
               out_valid, out_bytes);
    end
    vectors++;
    if (dx !== 9'h003 || dy !== 9'h104 || btn !== 3'd0) begin
      miscompares++;
      $display("FAIL rstmid_dec got %h/%h/%0d want 003/104/0",
               dx, dy, btn);
    end
    consume();
  endtask

  task automatic test_saturate();
    out_ready2 = 1'b0;
    for (int p = 0; p < 7; p++) begin
      send_byte2(8'h08);
      send_byte2(8'h01);
      send_byte2(8'h02);
      if (p == 2) begin
        vectors++;
        if (drop_count2 !== 2'd2) begin
          miscompares++;
          $display("FAIL sat_mid got %0d want 2", drop_count2);
        end
      end
    end
    vectors++;
    if (drop_count2 !== 2'd3 || out_valid2 !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_end got %0d/%0b want 3/1",
               drop_count2, out_valid2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_resync();
    test_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
